// File: rtl/gc_pkg.sv
// Shared constants for the GameCube controller poller: register offsets,
// command word, field widths and FSM state encodings.
package gc_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA_HI = 2'd2;
    localparam logic [1:0] REG_DATA_LO = 2'd3;

    localparam int CMD_W    = 24;
    localparam int RESP_W   = 64;
    localparam int BITCNT_W = 7;

    // Poll command; bit 0 is replaced by the rumble request at start
    localparam logic [CMD_W-1:0] CMD_POLL_HI = 24'h400300;

    typedef logic [2:0] gc_state_t;

    localparam gc_state_t ST_IDLE         = 3'd0;
    localparam gc_state_t ST_TX_LOW       = 3'd1;
    localparam gc_state_t ST_TX_HIGH      = 3'd2;
    localparam gc_state_t ST_STOP_LOW     = 3'd3;
    localparam gc_state_t ST_RX_WAIT_FALL = 3'd4;
    localparam gc_state_t ST_RX_SAMPLE    = 3'd5;
    localparam gc_state_t ST_RX_WAIT_RISE = 3'd6;

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the controller pad plus one-cycle rise/fall
// pulses; resets to the idle-high level so reset never fakes an edge.
module gc_line_sync
    import gc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign level = sync2_reg;
    assign rise  = sync2_reg & ~prev_reg;
    assign fall  = ~sync2_reg & prev_reg;

endmodule

// File: rtl/gc_ctrl_apb.sv
// APB3 slave that polls one GameCube controller over the open-drain line
// and exposes the 64-bit response, status and a level interrupt.
module gc_ctrl_apb
    import gc_pkg::*;
#(
    parameter int US_CYCLES  = 100,
    parameter int TIMEOUT_US = 200
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        GC_DATA_IN,
    output logic        GC_DATA_OE,
    output logic        IRQ
);

    localparam int TMR_W = $clog2(TIMEOUT_US * US_CYCLES + 1);
    localparam logic [TMR_W-1:0] T_1US = TMR_W'(US_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_2US = TMR_W'(2 * US_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_3US = TMR_W'(3 * US_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_TO  = TMR_W'(TIMEOUT_US * US_CYCLES - 1);

    // Timer loads are N-1 so a state lasts exactly N cycles
    function automatic logic [TMR_W-1:0] low_time(input logic b);
        return b ? T_1US : T_3US;
    endfunction

    function automatic logic [TMR_W-1:0] high_time(input logic b);
        return b ? T_3US : T_1US;
    endfunction

    logic line_level;
    logic line_rise;
    logic line_fall;

    gc_line_sync u_sync (
        .clk   (PCLK),
        .rst_n (PRESERN),
        .din   (GC_DATA_IN),
        .level (line_level),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    gc_state_t             state_reg, state_next;
    logic [TMR_W-1:0]      timer_reg, timer_next;
    logic [BITCNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [CMD_W-1:0]      cmd_reg, cmd_next;
    logic [RESP_W-1:0]     shift_reg, shift_next;
    logic [RESP_W-1:0]     data_reg;
    logic                  rumble_reg, irq_en_reg;
    logic                  done_reg, done_next;
    logic                  timeout_reg, timeout_next;
    logic                  oe_reg, irq_reg;
    logic                  rx_done, rx_timeout;

    logic mapped, apb_wr, wr_ctrl, wr_status, start_go, busy;
    logic unused_pwdata;

    assign mapped    = (PADDR[7:4] == 4'h0) && (PADDR[1:0] == 2'b00);
    assign apb_wr    = PSEL & PENABLE & PWRITE & mapped;
    assign wr_ctrl   = apb_wr && (PADDR[3:2] == REG_CTRL);
    assign wr_status = apb_wr && (PADDR[3:2] == REG_STATUS);
    assign busy      = (state_reg != ST_IDLE);
    assign start_go  = wr_ctrl & PWDATA[0] & ~busy;
    assign unused_pwdata = ^PWDATA[31:3];

    always_comb begin
        state_next   = state_reg;
        timer_next   = (timer_reg != '0) ? timer_reg - 1'b1 : timer_reg;
        bit_cnt_next = bit_cnt_reg;
        cmd_next     = cmd_reg;
        shift_next   = shift_reg;
        rx_done      = 1'b0;
        rx_timeout   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_go) begin
                    state_next   = ST_TX_LOW;
                    cmd_next     = CMD_POLL_HI | CMD_W'(PWDATA[1]);
                    timer_next   = low_time(cmd_next[CMD_W-1]);
                    bit_cnt_next = '0;
                end
            end
            ST_TX_LOW: begin
                if (timer_reg == '0) begin
                    state_next = ST_TX_HIGH;
                    timer_next = high_time(cmd_reg[CMD_W-1]);
                end
            end
            ST_TX_HIGH: begin
                if (timer_reg == '0) begin
                    if (bit_cnt_reg == BITCNT_W'(CMD_W - 1)) begin
                        state_next = ST_STOP_LOW;
                        timer_next = T_1US;
                    end else begin
                        state_next   = ST_TX_LOW;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        cmd_next     = {cmd_reg[CMD_W-2:0], 1'b0};
                        timer_next   = low_time(cmd_reg[CMD_W-2]);
                    end
                end
            end
            ST_STOP_LOW: begin
                if (timer_reg == '0) begin
                    state_next   = ST_RX_WAIT_FALL;
                    timer_next   = T_TO;
                    bit_cnt_next = '0;
                end
            end
            ST_RX_WAIT_FALL: begin
                if (line_fall) begin
                    state_next = ST_RX_SAMPLE;
                    timer_next = T_2US;
                end else if (timer_reg == '0) begin
                    state_next = ST_IDLE;
                    rx_timeout = 1'b1;
                end
            end
            ST_RX_SAMPLE: begin
                if (timer_reg == '0) begin
                    shift_next = {shift_reg[RESP_W-2:0], line_level};
                    if (bit_cnt_reg == BITCNT_W'(RESP_W - 1)) begin
                        state_next = ST_IDLE;
                        rx_done    = 1'b1;
                    end else begin
                        state_next   = ST_RX_WAIT_RISE;
                        timer_next   = T_TO;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_RX_WAIT_RISE: begin
                // A '1' bit has already risen by sample time, so a high level counts
                if (line_rise | line_level) begin
                    state_next = ST_RX_WAIT_FALL;
                    timer_next = T_TO;
                end else if (timer_reg == '0) begin
                    state_next = ST_IDLE;
                    rx_timeout = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Hardware set is applied last so it wins over a same-cycle W1C
    always_comb begin
        done_next    = done_reg;
        timeout_next = timeout_reg;
        if (wr_status && PWDATA[1]) done_next    = 1'b0;
        if (wr_status && PWDATA[2]) timeout_next = 1'b0;
        if (start_go) begin
            done_next    = 1'b0;
            timeout_next = 1'b0;
        end
        if (rx_done)    done_next    = 1'b1;
        if (rx_timeout) timeout_next = 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            cmd_reg     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            rumble_reg  <= 1'b0;
            irq_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            oe_reg      <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            cmd_reg     <= cmd_next;
            shift_reg   <= shift_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            oe_reg      <= (state_next == ST_TX_LOW) || (state_next == ST_STOP_LOW);
            irq_reg     <= irq_en_reg & (done_reg | timeout_reg);
            if (wr_ctrl) begin
                rumble_reg <= PWDATA[1];
                irq_en_reg <= PWDATA[2];
            end
            if (rx_done) data_reg <= shift_next;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && mapped) begin
            case (PADDR[3:2])
                REG_CTRL:    PRDATA = {29'd0, irq_en_reg, rumble_reg, 1'b0};
                REG_STATUS:  PRDATA = {29'd0, timeout_reg, done_reg, busy};
                REG_DATA_HI: PRDATA = data_reg[63:32];
                default:     PRDATA = data_reg[31:0];
            endcase
        end
    end

    assign PREADY     = 1'b1;
    assign PSLVERR    = 1'b0;
    assign GC_DATA_OE = oe_reg;
    assign IRQ        = irq_reg;

endmodule

// File: doc/gc_ctrl_apb.md
Name: gc_ctrl_apb

Overview:
- APB3 slave in the fabric, directly downstream of the MSS APB master port; FAB_CLK drives PCLK and M2F_RESET_N drives PRESERN.
- Polls one GameCube controller over the single-wire open-drain bus.
  - Transmits the 24-bit poll command.
  - Captures the 64-bit response.
  - Exposes the response plus status and interrupt to firmware through four 32-bit registers.

Parameters:
US_CYCLES, 100, PCLK cycles per microsecond (100 MHz FAB_CLK)
TIMEOUT_US, 200, max microseconds waiting for any controller edge before abort

Ports:
PCLK  in  1  fabric clock (FAB_CLK)
PRESERN  in  1  reset, asynchronous, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write
PADDR  in  8  byte address; [3:2] decoded
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied 1, zero wait states
PSLVERR  out  1  tied 0
GC_DATA_IN  in  1  raw pad input (asynchronous)
GC_DATA_OE  out  1  1 = drive line low, 0 = release (pull-up)
IRQ  out  1  level interrupt to MSS

Behaviour:
- Reset values:
  - PRDATA=0, GC_DATA_OE=0, IRQ=0.
  - All registers 0; FSM in IDLE.
  - Asserting reset mid-transfer releases the line on the same edge, asynchronously.
- APB protocol:
  - Write commits when PSEL&PENABLE&PWRITE.
  - Read data is combinational on PADDR during the access phase.
  - Unmapped offsets read 0; writes to them are ignored.
- Register map:
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 RUMBLE; bit2 IRQ_EN.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 TIMEOUT (W1C).
  - 0x08 DATA_HI: response bits 63:32 (RO).
  - 0x0C DATA_LO: response bits 31:0 (RO).
- Start and command:
  - START with BUSY=0 clears DONE/TIMEOUT and enters TX.
  - START with BUSY=1 is ignored.
  - Command is 0x4003_0r, with r = RUMBLE latched at start; sent MSB first.
- TX bit timing:
  - '0' = 3 us low then 1 us high.
  - '1' = 1 us low then 3 us high.
  - Stop = 1 us low, then release.
- Input path: GC_DATA_IN passes a 2-flop synchronizer; all edges are detected on the synchronized value.
- RX sampling:
  - Sample line 2 us after each detected falling edge.
  - Shift sample into a 64-bit shift register, MSB first.
  - Wait for the rising edge before arming for the next fall.
  - The controller stop bit after bit 63 is not awaited.
- FSM: IDLE -> TX_LOW -> TX_HIGH (x24) -> STOP_LOW -> RX_WAIT_FALL -> RX_SAMPLE -> RX_WAIT_RISE -> (x64) -> IDLE.
  - The timer reloads at each state entry.
- Completion: after the 64th sample the shift register is copied to DATA_HI/LO in one cycle, DONE=1, BUSY=0.
- Timeout:
  - Applies in RX_WAIT_FALL and RX_WAIT_RISE.
  - Fires when no edge arrives for TIMEOUT_US*US_CYCLES cycles.
  - Result: TIMEOUT=1, BUSY=0, DATA registers unchanged, line released.
- BUSY = (state != IDLE).
- IRQ = IRQ_EN & (DONE | TIMEOUT), registered; one cycle latency from the flag.
- Simultaneous W1C and hardware set of the same flag: the set wins.
- Timer width is clog2(TIMEOUT_US*US_CYCLES+1); bit counter is 7 bits. The timer counts down and does not wrap.
- A falling edge seen during TX is ignored: the block is driving the line.

Decomposition:
- Package gc_pkg:
  - Register offsets.
  - CMD_POLL_HI = 24'h400300.
  - Width constants.
  - FSM state enum.
- Sub-module gc_line_sync:
  - 2-flop synchronizer.
  - Rise/fall one-cycle pulse outputs.
  - Async active-low reset, synchronizer flops reset to 1 (idle high).

Test Plan:
- Reset, then read 0x00–0x0C and 0x10 -> all read 0; PREADY=1, PSLVERR=0, GC_DATA_OE=0, IRQ=0.
- Write CTRL=0x1 -> BUSY=1 next cycle; OE waveform decodes to 0x400300.
  - Bit1 low phase is exactly 100 cycles; bit0 low phase is 300 cycles.
  - Stop bit low phase is 100 cycles.
- Write CTRL=0x7 with a controller model replying 0x0080_8080_8080_8080 at 4 us/bit.
  - Sent last byte = 0x01.
  - DATA_HI=0x00808080, DATA_LO=0x80808080, DONE=1, IRQ=1.
  - Write STATUS=0x2 -> DONE=0, IRQ=0.
- No controller response -> TIMEOUT=1 exactly 20000 cycles after stop-bit release; BUSY=0; DATA registers keep prior values.
- Second START mid-RX -> ignored; transfer completes with correct data.
- Assert PRESERN low at RX bit 30 -> OE=0 immediately; all registers 0; a fresh START after reset completes normally.
